dram_responder: RTL and testbench

Synthesizable DRAM endpoint for the accelerator's `io_dram_cmd`/`io_dram_resp` burst interface: the responder side of the protocol that `Top` initiates. It accepts 512-bit line commands (16 × 32-bit words), stores writes in an internal line memory, and returns tagged responses in order after a fixed latency. It honours response back-pressure. It lets `Top` run standalone in RTL sim and on FPGA without the C DRAM model.

---
 rtl/dram_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_dram_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// dram_responder: DRAM endpoint for the io_dram_cmd / io_dram_resp line interface.
// Optional feature: define DRAM_RESPONDER_WRACK_EN to make writes return a zero-data response.
module dram_responder #(
  parameter int MEM_LINES_W = 10,
  parameter int LATENCY     = 4,
  parameter int DEPTH       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_dram_cmd_valid,
  output logic        io_dram_cmd_ready,
  input  logic [31:0] io_dram_cmd_bits_addr,
  input  logic        io_dram_cmd_bits_isWr,
  input  logic [31:0] io_dram_cmd_bits_tag,
  input  logic [31:0] io_dram_cmd_bits_streamId,
  input  logic [31:0] io_dram_cmd_bits_wdata_0,
  input  logic [31:0] io_dram_cmd_bits_wdata_1,
  input  logic [31:0] io_dram_cmd_bits_wdata_2,
  input  logic [31:0] io_dram_cmd_bits_wdata_3,
  input  logic [31:0] io_dram_cmd_bits_wdata_4,
  input  logic [31:0] io_dram_cmd_bits_wdata_5,
  input  logic [31:0] io_dram_cmd_bits_wdata_6,
  input  logic [31:0] io_dram_cmd_bits_wdata_7,
  input  logic [31:0] io_dram_cmd_bits_wdata_8,
  input  logic [31:0] io_dram_cmd_bits_wdata_9,
  input  logic [31:0] io_dram_cmd_bits_wdata_10,
  input  logic [31:0] io_dram_cmd_bits_wdata_11,
  input  logic [31:0] io_dram_cmd_bits_wdata_12,
  input  logic [31:0] io_dram_cmd_bits_wdata_13,
  input  logic [31:0] io_dram_cmd_bits_wdata_14,
  input  logic [31:0] io_dram_cmd_bits_wdata_15,
  output logic        io_dram_resp_valid,
  input  logic        io_dram_resp_ready,
  output logic [31:0] io_dram_resp_bits_rdata_0,
  output logic [31:0] io_dram_resp_bits_rdata_1,
  output logic [31:0] io_dram_resp_bits_rdata_2,
  output logic [31:0] io_dram_resp_bits_rdata_3,
  output logic [31:0] io_dram_resp_bits_rdata_4,
  output logic [31:0] io_dram_resp_bits_rdata_5,
  output logic [31:0] io_dram_resp_bits_rdata_6,
  output logic [31:0] io_dram_resp_bits_rdata_7,
  output logic [31:0] io_dram_resp_bits_rdata_8,
  output logic [31:0] io_dram_resp_bits_rdata_9,
  output logic [31:0] io_dram_resp_bits_rdata_10,
  output logic [31:0] io_dram_resp_bits_rdata_11,
  output logic [31:0] io_dram_resp_bits_rdata_12,
  output logic [31:0] io_dram_resp_bits_rdata_13,
  output logic [31:0] io_dram_resp_bits_rdata_14,
  output logic [31:0] io_dram_resp_bits_rdata_15,
  output logic [31:0] io_dram_resp_bits_tag,
  output logic [31:0] io_dram_resp_bits_streamId
);

  localparam int LINES  = 1 << MEM_LINES_W;
  localparam int LINE_W = 512;
  localparam int ENT_W  = LINE_W + 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [LINE_W-1:0]      r_mem [LINES];
  logic [MEM_LINES_W-1:0] w_idx;
  logic [LINE_W-1:0]      w_wline;
  logic                   w_accept;
  logic                   w_produce;
  logic                   w_push;
  logic                   w_pop;
  logic [ENT_W-1:0]       w_acc_ent;
  logic [ENT_W-1:0]       w_push_ent;
  logic [ENT_W-1:0]       w_head;
  logic [CNT_W-1:0]       r_outstanding;
  logic [CNT_W-1:0]       w_out_nxt;
  logic                   r_cmd_ready;
  logic [ENT_W-1:0]       r_fifo [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_fifo_cnt;
  logic                   w_resp_valid;
  logic                   w_unused;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Offset bits and bits above the index are dropped, so addresses wrap.
  assign w_idx    = io_dram_cmd_bits_addr[6+MEM_LINES_W-1:6];
  assign w_unused = ^io_dram_cmd_bits_addr;
  assign w_wline  = {io_dram_cmd_bits_wdata_15, io_dram_cmd_bits_wdata_14,
                     io_dram_cmd_bits_wdata_13, io_dram_cmd_bits_wdata_12,
                     io_dram_cmd_bits_wdata_11, io_dram_cmd_bits_wdata_10,
                     io_dram_cmd_bits_wdata_9,  io_dram_cmd_bits_wdata_8,
                     io_dram_cmd_bits_wdata_7,  io_dram_cmd_bits_wdata_6,
                     io_dram_cmd_bits_wdata_5,  io_dram_cmd_bits_wdata_4,
                     io_dram_cmd_bits_wdata_3,  io_dram_cmd_bits_wdata_2,
                     io_dram_cmd_bits_wdata_1,  io_dram_cmd_bits_wdata_0};

  assign w_accept = io_dram_cmd_valid & r_cmd_ready;

`ifdef DRAM_RESPONDER_WRACK_EN
  assign w_produce = 1'b1;
`else
  assign w_produce = ~io_dram_cmd_bits_isWr;
`endif

  // Response entry built at accept: {streamId, tag, line}; writes answer with zero data.
  always_comb begin
    w_acc_ent = {io_dram_cmd_bits_streamId, io_dram_cmd_bits_tag, {LINE_W{1'b0}}};
    if (!io_dram_cmd_bits_isWr) begin
      w_acc_ent[LINE_W-1:0] = r_mem[w_idx];
    end else begin
      w_acc_ent[LINE_W-1:0] = {LINE_W{1'b0}};
    end
  end

  // Line store: deliberately not reset so contents survive a mid-run reset.
  always_ff @(posedge clock) begin
    if (w_accept && io_dram_cmd_bits_isWr) begin
      r_mem[w_idx] <= w_wline;
    end
  end

  // The last latency stage is the FIFO write itself, hence LATENCY-1 registers.
  generate
    if (LATENCY == 1) begin : g_no_delay
      assign w_push     = w_accept & w_produce;
      assign w_push_ent = w_acc_ent;
    end else begin : g_delay
      localparam int STG = LATENCY - 1;
      logic [STG-1:0]   r_stg_vld;
      logic [ENT_W-1:0] r_stg_ent [STG];

      // Valid bits of the delay line.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_stg_vld <= {STG{1'b0}};
        end else begin
          r_stg_vld[0] <= w_accept & w_produce;
          for (int i = 1; i < STG; i++) begin
            r_stg_vld[i] <= r_stg_vld[i-1];
          end
        end
      end

      // Payload of the delay line; qualified by the valid bits.
      always_ff @(posedge clock) begin
        r_stg_ent[0] <= w_acc_ent;
        for (int i = 1; i < STG; i++) begin
          r_stg_ent[i] <= r_stg_ent[i-1];
        end
      end

      assign w_push     = r_stg_vld[STG-1];
      assign w_push_ent = r_stg_ent[STG-1];
    end
  endgenerate

  assign w_resp_valid = (r_fifo_cnt != {CNT_W{1'b0}});
  assign w_pop        = w_resp_valid & io_dram_resp_ready;

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_fifo_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Output FIFO storage.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_ent;
    end
  end

  // Outstanding credit: responses in the delay line plus the FIFO.
  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_accept & w_produce, w_pop})
      2'b10:   w_out_nxt = r_outstanding + CNT_W'(1);
      2'b01:   w_out_nxt = r_outstanding - CNT_W'(1);
      default: w_out_nxt = r_outstanding;
    endcase
  end

  // Credit counter and registered command ready (held low during reset).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_outstanding <= {CNT_W{1'b0}};
      r_cmd_ready   <= 1'b0;
    end else begin
      r_outstanding <= w_out_nxt;
      r_cmd_ready   <= (w_out_nxt < DEPTH_C);
    end
  end

  assign w_head = w_resp_valid ? r_fifo[r_rd_ptr] : {ENT_W{1'b0}};

  assign io_dram_cmd_ready          = r_cmd_ready;
  assign io_dram_resp_valid         = w_resp_valid;
  assign io_dram_resp_bits_rdata_0  = w_head[32*0  +: 32];
  assign io_dram_resp_bits_rdata_1  = w_head[32*1  +: 32];
  assign io_dram_resp_bits_rdata_2  = w_head[32*2  +: 32];
  assign io_dram_resp_bits_rdata_3  = w_head[32*3  +: 32];
  assign io_dram_resp_bits_rdata_4  = w_head[32*4  +: 32];
  assign io_dram_resp_bits_rdata_5  = w_head[32*5  +: 32];
  assign io_dram_resp_bits_rdata_6  = w_head[32*6  +: 32];
  assign io_dram_resp_bits_rdata_7  = w_head[32*7  +: 32];
  assign io_dram_resp_bits_rdata_8  = w_head[32*8  +: 32];
  assign io_dram_resp_bits_rdata_9  = w_head[32*9  +: 32];
  assign io_dram_resp_bits_rdata_10 = w_head[32*10 +: 32];
  assign io_dram_resp_bits_rdata_11 = w_head[32*11 +: 32];
  assign io_dram_resp_bits_rdata_12 = w_head[32*12 +: 32];
  assign io_dram_resp_bits_rdata_13 = w_head[32*13 +: 32];
  assign io_dram_resp_bits_rdata_14 = w_head[32*14 +: 32];
  assign io_dram_resp_bits_rdata_15 = w_head[32*15 +: 32];
  assign io_dram_resp_bits_tag      = w_head[LINE_W    +: 32];
  assign io_dram_resp_bits_streamId = w_head[LINE_W+32 +: 32];

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: directed self-checking bench for dram_responder (LATENCY 4, DEPTH 8).
// Honours DRAM_RESPONDER_WRACK_EN the same way the design does.
module tb_dram_responder;

  localparam int LAT = 4;
  localparam logic [31:0] SID_X = 32'h5A00_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_iswr, resp_valid, resp_ready;
  logic [31:0] cmd_addr, cmd_tag, cmd_sid, resp_tag, resp_sid;
  logic [31:0] wd [16];
  logic [31:0] rd [16];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc;

  dram_responder #(.MEM_LINES_W(10), .LATENCY(LAT), .DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .io_dram_cmd_valid(cmd_valid), .io_dram_cmd_ready(cmd_ready),
    .io_dram_cmd_bits_addr(cmd_addr), .io_dram_cmd_bits_isWr(cmd_iswr),
    .io_dram_cmd_bits_tag(cmd_tag), .io_dram_cmd_bits_streamId(cmd_sid),
    .io_dram_cmd_bits_wdata_0(wd[0]),   .io_dram_cmd_bits_wdata_1(wd[1]),
    .io_dram_cmd_bits_wdata_2(wd[2]),   .io_dram_cmd_bits_wdata_3(wd[3]),
    .io_dram_cmd_bits_wdata_4(wd[4]),   .io_dram_cmd_bits_wdata_5(wd[5]),
    .io_dram_cmd_bits_wdata_6(wd[6]),   .io_dram_cmd_bits_wdata_7(wd[7]),
    .io_dram_cmd_bits_wdata_8(wd[8]),   .io_dram_cmd_bits_wdata_9(wd[9]),
    .io_dram_cmd_bits_wdata_10(wd[10]), .io_dram_cmd_bits_wdata_11(wd[11]),
    .io_dram_cmd_bits_wdata_12(wd[12]), .io_dram_cmd_bits_wdata_13(wd[13]),
    .io_dram_cmd_bits_wdata_14(wd[14]), .io_dram_cmd_bits_wdata_15(wd[15]),
    .io_dram_resp_valid(resp_valid), .io_dram_resp_ready(resp_ready),
    .io_dram_resp_bits_rdata_0(rd[0]),   .io_dram_resp_bits_rdata_1(rd[1]),
    .io_dram_resp_bits_rdata_2(rd[2]),   .io_dram_resp_bits_rdata_3(rd[3]),
    .io_dram_resp_bits_rdata_4(rd[4]),   .io_dram_resp_bits_rdata_5(rd[5]),
    .io_dram_resp_bits_rdata_6(rd[6]),   .io_dram_resp_bits_rdata_7(rd[7]),
    .io_dram_resp_bits_rdata_8(rd[8]),   .io_dram_resp_bits_rdata_9(rd[9]),
    .io_dram_resp_bits_rdata_10(rd[10]), .io_dram_resp_bits_rdata_11(rd[11]),
    .io_dram_resp_bits_rdata_12(rd[12]), .io_dram_resp_bits_rdata_13(rd[13]),
    .io_dram_resp_bits_rdata_14(rd[14]), .io_dram_resp_bits_rdata_15(rd[15]),
    .io_dram_resp_bits_tag(resp_tag), .io_dram_resp_bits_streamId(resp_sid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] tag,
                         input logic [31:0] base);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_iswr  = wr;
    cmd_tag   = tag;
    cmd_sid   = tag ^ SID_X;
    for (int i = 0; i < 16; i++) wd[i] = base + 32'(i);
  endtask

  task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] tag,
                      input logic [31:0] base);
    int n = 0;
    set_cmd(addr, wr, tag, base);
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (!resp_valid && n < budget) begin
      step();
      n++;
    end
    chk("resp_wait", 32'(resp_valid), 32'd1);
  endtask

  task automatic chk_resp(input string name, input logic [31:0] tag, input logic [31:0] base,
                          input logic zero);
    chk({name, "_valid"}, 32'(resp_valid), 32'd1);
    chk({name, "_tag"}, resp_tag, tag);
    chk({name, "_sid"}, resp_sid, tag ^ SID_X);
    for (int i = 0; i < 16; i++)
      chk({name, "_rdata"}, rd[i], zero ? 32'd0 : base + 32'(i));
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_iswr = 1'b0; cmd_tag = 32'd0; cmd_sid = 32'd0;
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) wd[i] = 32'd0;

    // Reset state
    step(); step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_tag", resp_tag, 32'd0);
    chk("rst_sid", resp_sid, 32'd0);
    chk("rst_rdata0", rd[0], 32'd0);
    chk("rst_rdata15", rd[15], 32'd0);
    reset = 1'b1;
    step();
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Write line 1 then read it through an unaligned address; check latency
    send(32'h40, 1'b1, 32'd7, 32'h100);
    send(32'h7F, 1'b0, 32'd9, 32'h0);
    chk("t1_lat0", 32'(resp_valid), 32'd0);
    step();
    chk("t1_lat1", 32'(resp_valid), 32'd0);
    step();
`ifdef DRAM_RESPONDER_WRACK_EN
    chk_resp("t1_wr_ack", 32'd7, 32'd0, 1'b1);
`else
    chk("t1_lat2", 32'(resp_valid), 32'd0);
`endif
    step();
    chk_resp("t1_read", 32'd9, 32'h100, 1'b0);
    step();
    chk("t1_drain", 32'(resp_valid), 32'd0);

    // Address wrap-around
    send(32'hC0, 1'b1, 32'h21, 32'h300);
`ifdef DRAM_RESPONDER_WRACK_EN
    wait_resp(20); chk_resp("t2_wr_ack", 32'h21, 32'd0, 1'b1); step();
`endif
    send(32'hC0 + 32'h0001_0000, 1'b0, 32'h22, 32'h0);
    wait_resp(20); chk_resp("t2_wrap", 32'h22, 32'h300, 1'b0); step();

    // Read on the edge right after the write
    send(32'h140, 1'b1, 32'h31, 32'h500);
    send(32'h140, 1'b0, 32'h32, 32'h0);
`ifdef DRAM_RESPONDER_WRACK_EN
    wait_resp(20); chk_resp("t5_wr_ack", 32'h31, 32'd0, 1'b1); step();
`endif
    wait_resp(20); chk_resp("t5_raw", 32'h32, 32'h500, 1'b0); step();

    // Back-pressure: 12 attempts, 8 accepted
    resp_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 12; k++) begin
      set_cmd(32'h140, 1'b0, 32'h40 + 32'(n_acc), 32'h0);
      if (cmd_ready) n_acc++;
      step();
    end
    cmd_valid = 1'b0;
    chk("t3_accepted", 32'(n_acc), 32'd8);
    chk("t3_ready_low", 32'(cmd_ready), 32'd0);
    chk("t3_head0", resp_tag, 32'h40);
    resp_ready = 1'b1;
    chk("t3_ready_before_hs", 32'(cmd_ready), 32'd0);
    step();
    chk("t3_ready_after_hs", 32'(cmd_ready), 32'd1);
    chk("t3_head1", resp_tag, 32'h41);
    set_cmd(32'h140, 1'b0, 32'h48, 32'h0);
    step();
    cmd_valid = 1'b0;
    resp_ready = 1'b0;
    chk("t5_same_cycle_ready", 32'(cmd_ready), 32'd1);
    chk("t5_same_cycle_head", resp_tag, 32'h42);
    set_cmd(32'h140, 1'b0, 32'h49, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("t5_full_again", 32'(cmd_ready), 32'd0);
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_resp(20);
      chk("t3_order", resp_tag, 32'h42 + 32'(k));
      chk("t3_data", rd[0], 32'h500);
      step();
    end
    chk("t3_empty", 32'(resp_valid), 32'd0);
    chk("t3_ready_back", 32'(cmd_ready), 32'd1);

    // Back-to-back reads of 16 distinct lines
    for (int k = 0; k < 16; k++)
      send(32'((16 + k) * 64), 1'b1, 32'h60 + 32'(k), 32'h1000 * 32'(k + 1));
    repeat (LAT + 2) step();
    chk("t4_idle", 32'(resp_valid), 32'd0);
    for (int c = 0; c < 16 + LAT - 1; c++) begin
      if (c < 16) set_cmd(32'((16 + c) * 64), 1'b0, 32'h70 + 32'(c), 32'h0);
      else cmd_valid = 1'b0;
      chk("t4_ready", 32'(cmd_ready), 32'd1);
      step();
      if (c >= LAT - 1)
        chk_resp("t4_stream", 32'h70 + 32'(c - LAT + 1), 32'h1000 * 32'(c - LAT + 2), 1'b0);
    end
    cmd_valid = 1'b0;
    step();
    chk("t4_done", 32'(resp_valid), 32'd0);

    // Reset with 5 outstanding; memory survives
    resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_cmd(32'hC0, 1'b0, 32'h80 + 32'(k), 32'h0);
      step();
    end
    cmd_valid = 1'b0;
    repeat (2) step();
    chk("t6_pre_valid", 32'(resp_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(resp_valid), 32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("t6_ready_rel", 32'(cmd_ready), 32'd1);
    chk("t6_valid_rel", 32'(resp_valid), 32'd0);
    resp_ready = 1'b1;
    send(32'hC0, 1'b0, 32'h90, 32'h0);
    wait_resp(20);
    chk_resp("t6_retained", 32'h90, 32'h300, 1'b0);
    step();
    chk("t6_done", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
